// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master picorv32 native-bus arbiter onto one memory port, with a slave wait timeout
// Ports: clk, rst (sync, active-high);
//   m0_*/m1_*  : master request (valid, instr, addr, wdata, wstrb) in; completion (ready, rdata) out
//   s_*        : granted request toward memory out; s_ready/s_rdata completion in
//   err_timeout: pulses when a stalled access is force-completed with 32'hDEADBEEF
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 wins every tie.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        g0, g1, req_valid, timeout, done, pick1;
  logic [31:0] rdata_g;
  always_comb begin
    g0        = state_q == GRANT0;
    g1        = state_q == GRANT1;
    req_valid = (g0 && m0_valid) || (g1 && m1_valid);
    // a slave completion arriving on the timeout cycle still wins
    timeout   = req_valid && !s_ready && cnt_q == 16'(TIMEOUT);
    done      = req_valid && (s_ready || timeout);
    rdata_g   = timeout ? 32'hDEADBEEF : s_rdata;
  end
`ifdef ARB_ROUND_ROBIN_EN
  // last_q holds the master that completed most recently; the other one wins a tie
  logic last_q;
  assign pick1 = m1_valid && (!m0_valid || !last_q);
  always_ff @(posedge clk)
    last_q <= rst ? 1'b1 : done ? g1 : last_q;
`else
  assign pick1 = m1_valid && !m0_valid;
`endif
  // the counter sits at zero in IDLE, so every grant starts counting from zero;
  // leaving a grant always passes through IDLE, giving the one-cycle gap between grants
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    if (state_q == IDLE) begin
      state_d = pick1 ? GRANT1 : m0_valid ? GRANT0 : IDLE;
      cnt_d   = '0;
    end else if (!req_valid || done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
  // outputs are forced low while rst is high, so a transfer caught by reset never completes
  always_comb begin
    s_valid     = !rst && req_valid && !timeout;
    s_instr     = !rst && (g0 ? m0_instr : g1 && m1_instr);
    s_addr      = rst ? '0 : g0 ? m0_addr : g1 ? m1_addr : '0;
    s_wdata     = rst ? '0 : g0 ? m0_wdata : g1 ? m1_wdata : '0;
    s_wstrb     = rst ? '0 : g0 ? m0_wstrb : g1 ? m1_wstrb : '0;
    m0_ready    = !rst && g0 && done;
    m1_ready    = !rst && g1 && done;
    m0_rdata    = (!rst && g0) ? rdata_g : '0;
    m1_rdata    = (!rst && g1) ? rdata_g : '0;
    err_timeout = !rst && timeout;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (TIMEOUT=4)
module tb_mem_arbiter;
  logic        clk, rst;
  logic        m0_valid, m0_instr, m0_ready, m1_valid, m1_instr, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_instr, s_ready, err_timeout;
  logic [31:0] s_addr, s_wdata, s_rdata;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_timeout(err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        m;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic        to;
  } vec_t;
  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic samp();
    exp_t e;
    @(negedge clk);
    if (m0_ready || m1_ready || err_timeout) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_spurious: got m1/m0_ready=%b%b err=%b, expected no completion", m1_ready, m0_ready, err_timeout);
      end else begin
        e = sbq.pop_front();
        chk("sb_master", 32'({m1_ready, m0_ready}), e.m ? 32'd2 : 32'd1);
        chk("sb_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
        chk("sb_err", 32'(err_timeout), 32'(e.err));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic v, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (m) begin
      m1_valid = v; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = v; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
  endtask

  initial begin
    logic order[4];
    vec_t v;
    int   last;
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 2,  32'h12345678, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h40,   32'hCAFEF00D, 4'hF, 0,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h2000, 32'h0,        4'h0, 1,  32'h00000013, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h8,    32'h55AA,     4'h3, 3,  32'hFFFFFFFF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h200,  32'h0,        4'h0, 4,  32'h0BADF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h300,  32'h0,        4'h0, 15, 32'h11111111, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h400,  32'h0,        4'h0, 15, 32'h22222222, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h500,  32'h0,        4'h0, 4,  32'h76543210, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // reset with live request and slave completion: everything must stay quiet
    rst = 1; s_ready = 1; s_rdata = 32'hFFFF0000;
    m0_valid = 1; m0_addr = 32'h10;
    adv(); adv();
    samp();
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_m0_ready", 32'(m0_ready), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_err", 32'(err_timeout), 0);
    adv();
    rst = 0;
    // both masters held valid, slave always ready
    drive(0, 1, 0, 32'h10, 0, 0);
    drive(1, 1, 0, 32'h20, 0, 0);
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'hA0000000 + 32'(i);
      sbq.push_back('{order[i], s_rdata, 1'b0});
      samp();
      chk("arb_gap_svalid", 32'(s_valid), 0);
      adv();
      samp();
      chk("arb_saddr", s_addr, order[i] ? 32'h20 : 32'h10);
      adv();
    end
    // the waiting master is served once the other lets go
    m0_valid = 0;
    s_rdata = 32'hB0000001;
    sbq.push_back('{1'b1, s_rdata, 1'b0});
    samp(); adv();
    samp();
    chk("arb_m1_saddr", s_addr, 32'h20);
    adv();
    m1_valid = 0;
    s_ready = 0;
    // single-master transactions with varying slave latency, incl. timeout boundary
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      last = v.to ? 4 : v.lat;
      drive(v.m, 1, v.instr, v.addr, v.wdata, v.wstrb);
      s_ready = 0;
      s_rdata = v.rdata;
      sbq.push_back('{v.m, v.to ? 32'hDEADBEEF : v.rdata, v.to});
      samp();
      chk("idle_svalid", 32'(s_valid), 0);
      chk("idle_saddr", s_addr, 0);
      adv();
      for (int k = 0; k <= last; k++) begin
        s_ready = (k == v.lat);
        samp();
        chk("g_svalid", 32'(s_valid), (k == last && v.to) ? 32'd0 : 32'd1);
        chk("g_saddr", s_addr, v.addr);
        chk("g_swdata", s_wdata, v.wdata);
        chk("g_swstrb", 32'(s_wstrb), 32'(v.wstrb));
        chk("g_sinstr", 32'(s_instr), 32'(v.instr));
        chk("g_ready", 32'(v.m ? m1_ready : m0_ready), 32'(k == last));
        chk("g_other_rdata", v.m ? m0_rdata : m1_rdata, 0);
        adv();
      end
      drive(v.m, 0, 0, 0, 0, 0);
      s_ready = 1;
      samp();
      chk("post_svalid", 32'(s_valid), 0);
      chk("post_idle_ready", 32'({m1_ready, m0_ready}), 0);
      adv();
      s_ready = 0;
    end
    // master drops valid while granted: no completion, back to idle, then m1 served
    drive(0, 1, 0, 32'h600, 0, 0);
    samp(); adv();
    m0_valid = 0;
    drive(1, 1, 0, 32'h700, 0, 0);
    s_ready = 1;
    samp();
    chk("viol_svalid", 32'(s_valid), 0);
    chk("viol_m0_ready", 32'(m0_ready), 0);
    adv();
    s_ready = 0;
    samp();
    chk("viol_idle_svalid", 32'(s_valid), 0);
    adv();
    s_ready = 1;
    s_rdata = 32'h00000077;
    sbq.push_back('{1'b1, 32'h00000077, 1'b0});
    samp();
    chk("viol_m1_saddr", s_addr, 32'h700);
    chk("viol_m1_svalid", 32'(s_valid), 1);
    adv();
    m1_valid = 0;
    s_ready = 0;
    // reset during GRANT0 aborts the transfer
    drive(0, 1, 0, 32'h800, 0, 0);
    samp(); adv();
    samp();
    chk("mrst_pre_svalid", 32'(s_valid), 1);
    adv();
    rst = 1;
    s_ready = 1;
    samp();
    chk("mrst_m0_ready", 32'(m0_ready), 0);
    chk("mrst_svalid", 32'(s_valid), 0);
    adv();
    rst = 0;
    m0_valid = 0;
    s_ready = 0;
    samp();
    chk("mrst_after_svalid", 32'(s_valid), 0);
    chk("mrst_after_ready", 32'(m0_ready), 0);
    adv();
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
